memory_port_arbiter: RTL and testbench
======================================

# memory_port_arbiter

Two-requester round-robin arbiter for the processor's single shared memory port. Requester 0 is instruction fetch and requester 1 is data load/store. The block owns the `selector` of the 32-bit `multiplexer_2to1` instances that steer address and write data onto the port. It sequences each access with a valid/ready handshake to memory and returns read data plus a one-cycle `done` pulse to the winner.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of the data buses.
- `ADDR_WIDTH`, 32, width of the address buses.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clock`.
- `request0`, `request1`  in  1  access request, held high until the matching `done` is seen.
- `address0`, `address1`  in  ADDR_WIDTH  request address, stable while the request is high.
- `write_data0`, `write_data1`  in  DATA_WIDTH  store data, stable while the request is high.
- `write_enable0`, `write_enable1`  in  1  1 = store, 0 = load.
- `done0`, `done1`  out  1  one-cycle completion pulse.
- `read_data`  out  DATA_WIDTH  registered load result, valid in the `done` cycle and held until the next completion.
- `mem_address`  out  ADDR_WIDTH  muxed address (mux output, input0 = `address0`).
- `mem_write_data`  out  DATA_WIDTH  muxed store data.
- `mem_write_enable`  out  1  `write_enable` of the granted requester, qualified by `mem_valid`.
- `mem_valid`  out  1  access in progress.
- `mem_ready`  in  1  memory accepts and completes the access this cycle.
- `mem_read_data`  in  DATA_WIDTH  load data, valid when `mem_ready` = 1.
- `selector`  out  1  granted requester; drives the address and write-data muxes.
- `grant0`, `grant1`  out  1  one-hot grant, high for the whole BUSY period.

## Operation
- State machine has two states:
  - IDLE: `mem_valid` = 0.
  - BUSY: `mem_valid` = 1, grant held.
- Arbitration happens on the IDLE rising edge. An eligible requester is one whose request is high and which is not masked.
  - No eligible requester: stay in IDLE.
  - One eligible requester: it wins.
  - Both eligible: the requester that was not granted last (`last_grant`) wins.
  - On a win: register `selector`, set the winner's `grant`, update `last_grant`, go to BUSY.
- Mask: in the IDLE cycle where `doneX` = 1, `requestX` is ignored. A requester that still holds `request` high is re-arbitrated one cycle later.
- BUSY with `mem_ready` = 0: hold state, `selector`, grants and `mem_valid`.
- BUSY with `mem_ready` = 1:
  - Load `mem_read_data` into `read_data`. This happens for stores too; the value is don't-care.
  - Pulse the winner's `done` in the next cycle.
  - Clear the grants and return to IDLE.
- A requester dropping its request while BUSY is a protocol error. The access still completes and `done` still pulses.
- A lone requester may win back-to-back; there is no forced alternation.
- Reset (`reset_n` = 0 at a rising edge):
  - State goes to IDLE; `selector`, `grant0/1`, `done0/1` and `mem_valid` go to 0.
  - `read_data` goes to 0.
  - `last_grant` goes to 1, so requester 0 wins the first tie.
  - Reset mid-access abandons the access with no `done` pulse.
- Reset value of the muxed outputs: `mem_address` and `mem_write_data` follow `address0` and `write_data0`. `mem_write_enable` is 0.

## Timing
- Request high at edge k in IDLE: `grant`, `selector` and `mem_valid` are high in the cycle after edge k.
- Zero-wait memory (`mem_ready` high at the first BUSY edge k+1): `done` and `read_data` valid after edge k+1; back in IDLE.
- Each wait cycle with `mem_ready` = 0 adds one cycle.
- Peak throughput is one access per 2 cycles, because of the IDLE arbitration cycle.
- `mem_address` and `mem_write_data` are combinational from the requester inputs through the mux; the requester must keep them stable while its grant is high.
- All other outputs are registered.

## Test plan
- Reset: hold `reset_n` = 0 for 2 cycles with both requests high and `mem_ready` = 1.
  - All registered outputs 0, `mem_valid` = 0.
  - First grant after release goes to requester 0.
- Single load:
  - Stimulus: `request0`, `address0` = 0x100, `mem_ready` raised on the 3rd BUSY cycle, `mem_read_data` = 0xDEADBEEF.
  - Required: `mem_valid` high for exactly 3 cycles, `mem_address` = 0x100, `selector` = 0.
  - Required: `done0` is one pulse, `read_data` = 0xDEADBEEF, `done1` stays 0.
- Contention:
  - Stimulus: both requests held high, `address0` = 0x100, `address1` = 0x200, `mem_ready` always 1.
  - Required: grants alternate 0,1,0,1; `mem_address` alternates 0x100/0x200; one `done` every 2 cycles.
- Lone repeat: `request1` held high with `write_enable1` = 1 and `write_data1` = 0x12345678 for 3 accesses, `request0` = 0.
  - Required: 3 consecutive grants to requester 1.
  - Required: `mem_write_enable` = 1 and `mem_write_data` = 0x12345678 whenever `mem_valid` is high.
- Reset mid-access: assert `reset_n` = 0 in the 2nd BUSY cycle with `mem_ready` = 0.
  - Required: `mem_valid` = 0 and grants 0 the next cycle, no `done` pulse.
- Mask: `request0` held high one cycle after `done0`, with `request1` = 0.
  - Required: no arbitration in the `done0` cycle; regrant to requester 0 exactly one cycle later.

Source files
------------

// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter that shares one memory port between instruction fetch (0)
// and data load/store (1), sequencing each access with a valid/ready handshake.
module memory_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  request0,
  input  logic                  request1,
  input  logic [ADDR_WIDTH-1:0] address0,
  input  logic [ADDR_WIDTH-1:0] address1,
  input  logic [DATA_WIDTH-1:0] write_data0,
  input  logic [DATA_WIDTH-1:0] write_data1,
  input  logic                  write_enable0,
  input  logic                  write_enable1,
  output logic                  done0,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_enable,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  selector,
  output logic                  grant0,
  output logic                  grant1
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                state_q;
  logic                  selector_q;
  logic                  grant0_q;
  logic                  grant1_q;
  logic                  done0_q;
  logic                  done1_q;
  logic                  mem_valid_q;
  logic                  mem_we_q;
  logic                  last_grant_q;
  logic [DATA_WIDTH-1:0] read_data_q;

  logic                  elig0_s;
  logic                  elig1_s;
  logic                  winner_s;
  logic                  winner_we_s;

  // Eligibility (a requester is masked in its own done cycle) and round-robin pick.
  always_comb begin
    elig0_s = request0 & ~done0_q;
    elig1_s = request1 & ~done1_q;
    if (elig0_s && elig1_s) begin
      winner_s = ~last_grant_q;
    end else if (elig1_s) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
    if (winner_s) begin
      winner_we_s = write_enable1;
    end else begin
      winner_we_s = write_enable0;
    end
  end

  // Access sequencer: arbitrate in IDLE, hold the grant in BUSY until mem_ready.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      selector_q   <= 1'b0;
      grant0_q     <= 1'b0;
      grant1_q     <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      last_grant_q <= 1'b1;
      read_data_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (elig0_s || elig1_s) begin
            state_q      <= BUSY;
            selector_q   <= winner_s;
            grant0_q     <= ~winner_s;
            grant1_q     <= winner_s;
            last_grant_q <= winner_s;
            mem_valid_q  <= 1'b1;
            mem_we_q     <= winner_we_s;
          end
        end
        BUSY: begin
          // Read data is captured for stores too; the requester ignores it.
          if (mem_ready) begin
            state_q     <= IDLE;
            read_data_q <= mem_read_data;
            done0_q     <= ~selector_q;
            done1_q     <= selector_q;
            grant0_q    <= 1'b0;
            grant1_q    <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          grant0_q    <= 1'b0;
          grant1_q    <= 1'b0;
          mem_valid_q <= 1'b0;
          mem_we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign mem_address      = selector_q ? address1 : address0;
  assign mem_write_data   = selector_q ? write_data1 : write_data0;
  assign mem_write_enable = mem_we_q;
  assign mem_valid        = mem_valid_q;
  assign selector         = selector_q;
  assign grant0           = grant0_q;
  assign grant1           = grant1_q;
  assign done0            = done0_q;
  assign done1            = done1_q;
  assign read_data        = read_data_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Scoreboard bench for memory_port_arbiter: directed scenarios followed by
// randomized traffic, checked against a transaction-level arbitration model.
module tb_memory_port_arbiter;

  typedef struct {
    bit          id;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          we;
    int          wt;
    logic [31:0] rdata;
  } rec_t;

  logic        clock;
  logic        reset_n;
  logic        req [2];
  logic [31:0] addr [2];
  logic [31:0] wd [2];
  logic        we [2];
  logic        done0, done1, mem_write_enable, mem_valid, mem_ready;
  logic        selector, grant0, grant1;
  logic [31:0] read_data, mem_address, mem_write_data, mem_read_data;

  int checks = 0;
  int failures = 0;

  rec_t        exp_q[$];
  bit          busy = 1'b0;
  bit          owner = 1'b0;
  bit          last = 1'b1;
  bit          exp_done0 = 1'b0;
  bit          exp_done1 = 1'b0;
  int          comp = 0;
  int          tcyc = 0;
  int          force_wait = 0;
  bit          force_rd = 1'b0;
  logic [31:0] force_rd_val = 32'h0;
  int          rcnt = 0;

  int left [2];
  int gap [2];
  int done_ids[$];
  int done_cyc[$];

  memory_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .request0(req[0]), .request1(req[1]),
    .address0(addr[0]), .address1(addr[1]),
    .write_data0(wd[0]), .write_data1(wd[1]),
    .write_enable0(we[0]), .write_enable1(we[1]),
    .done0(done0), .done1(done1), .read_data(read_data),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_read_data(mem_read_data),
    .selector(selector), .grant0(grant0), .grant1(grant1)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one access at a time; a free port arbitrates among
  // requesters that are high and did not complete in the previous cycle.
  initial begin
    bit   od0, od1, e0, e1, w;
    rec_t r;
    forever begin
      @(posedge clock);
      tcyc++;
      if (!reset_n) begin
        busy = 1'b0; last = 1'b1; exp_done0 = 1'b0; exp_done1 = 1'b0;
        exp_q.delete();
      end else begin
        od0 = exp_done0; od1 = exp_done1;
        exp_done0 = 1'b0; exp_done1 = 1'b0;
        if (busy) begin
          if (tcyc == comp) begin
            busy = 1'b0;
            if (owner) exp_done1 = 1'b1; else exp_done0 = 1'b1;
          end
        end else begin
          e0 = req[0] && !od0;
          e1 = req[1] && !od1;
          if (e0 || e1) begin
            w = (e0 && e1) ? !last : e1;
            r.id = w; r.addr = addr[w]; r.wdata = wd[w]; r.we = we[w];
            r.wt = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
            r.rdata = force_rd ? force_rd_val : $urandom;
            exp_q.push_back(r);
            busy = 1'b1; owner = w; last = w;
            comp = tcyc + 1 + r.wt;
          end
        end
      end
    end
  end

  // Monitor and memory responder, both on the falling edge.
  initial begin
    rec_t r;
    forever begin
      @(negedge clock);
      chk(mem_valid === busy, "mem_valid", 64'(mem_valid), 64'(busy));
      chk(done0 === exp_done0, "done0", 64'(done0), 64'(exp_done0));
      chk(done1 === exp_done1, "done1", 64'(done1), 64'(exp_done1));
      if (mem_valid && exp_q.size() > 0) begin
        r = exp_q[0];
        chk(selector === r.id, "selector", 64'(selector), 64'(r.id));
        chk(grant0 === !r.id && grant1 === r.id, "grant", {grant1, grant0}, {r.id, !r.id});
        chk(mem_address === r.addr, "mem_address", mem_address, r.addr);
        chk(mem_write_data === r.wdata, "mem_write_data", mem_write_data, r.wdata);
        chk(mem_write_enable === r.we, "mem_write_enable", 64'(mem_write_enable), 64'(r.we));
      end else if (!mem_valid) begin
        chk(grant0 === 1'b0 && grant1 === 1'b0, "grant_idle", {grant1, grant0}, 64'h0);
        chk(mem_write_enable === 1'b0, "we_idle", 64'(mem_write_enable), 64'h0);
      end
      if (done0 || done1) begin
        chk(exp_q.size() > 0, "done_unexpected", {done1, done0}, 64'h0);
        if (exp_q.size() > 0) begin
          r = exp_q.pop_front();
          chk(done1 === r.id, "done_id", 64'(done1), 64'(r.id));
          chk(read_data === r.rdata, "read_data", read_data, r.rdata);
        end
      end
      if (mem_valid && exp_q.size() > 0) begin
        if (rcnt == exp_q[0].wt) begin
          mem_ready = 1'b1; mem_read_data = exp_q[0].rdata; rcnt = 0;
        end else begin
          mem_ready = 1'b0; mem_read_data = $urandom; rcnt++;
        end
      end else begin
        mem_ready = 1'b1; mem_read_data = $urandom; rcnt = 0;
      end
    end
  end

  task automatic new_txn(input int i);
    left[i]--;
    addr[i] = $urandom;
    wd[i] = $urandom;
    we[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic auto_step();
    for (int i = 0; i < 2; i++) begin
      if (req[i]) begin
        if ((i == 0) ? done0 : done1) begin
          if (left[i] > 0 && $urandom_range(0, 1) == 0) new_txn(i);
          else begin req[i] = 1'b0; gap[i] = $urandom_range(0, 3); end
        end
      end else if (left[i] > 0) begin
        if (gap[i] == 0) begin new_txn(i); req[i] = 1'b1; end
        else gap[i]--;
      end
    end
  endtask

  // Record completions; each requester drops its request on its own done once ndone seen.
  task automatic run_until(input int ndone);
    int seen = 0;
    done_ids.delete(); done_cyc.delete();
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      if (done0) begin
        done_ids.push_back(0); done_cyc.push_back(c); seen++;
        if (seen >= ndone) req[0] = 1'b0;
      end
      if (done1) begin
        done_ids.push_back(1); done_cyc.push_back(c); seen++;
        if (seen >= ndone) req[1] = 1'b0;
      end
      if (!req[0] && !req[1] && !mem_valid) return;
    end
    chk(1'b0 == (req[0] | req[1]), "run_timeout", 64'(seen), 64'(ndone));
  endtask

  initial begin
    int vcnt;
    bit got;
    reset_n = 1'b0;
    mem_ready = 1'b1; mem_read_data = 32'h0;
    req[0] = 1'b1; req[1] = 1'b1;
    addr[0] = 32'h100; addr[1] = 32'h200;
    wd[0] = 32'hA5A5_0000; wd[1] = 32'h5A5A_1111;
    we[0] = 1'b0; we[1] = 1'b0;
    force_wait = 0;

    // Reset with both requests high.
    repeat (2) @(negedge clock);
    chk(mem_valid === 1'b0, "rst_valid", 64'(mem_valid), 64'h0);
    chk({grant1, grant0, done1, done0, selector} === 5'b0, "rst_ctrl",
        {grant1, grant0, done1, done0, selector}, 64'h0);
    chk(read_data === 32'h0, "rst_read_data", read_data, 64'h0);
    chk(mem_address === addr[0], "rst_mem_address", mem_address, addr[0]);
    chk(mem_write_data === wd[0], "rst_mem_wdata", mem_write_data, wd[0]);
    reset_n = 1'b1;
    @(negedge clock);
    chk(grant0 === 1'b1 && selector === 1'b0, "first_tie_to_0", {grant1, grant0}, 64'h1);
    run_until(2);

    // Single load with two wait cycles.
    @(negedge clock);
    force_wait = 2; force_rd = 1'b1; force_rd_val = 32'hDEAD_BEEF;
    addr[0] = 32'h100; we[0] = 1'b0; req[0] = 1'b1;
    vcnt = 0; got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clock);
      if (mem_valid) vcnt++;
      if (done0) got = 1'b1;
    end
    chk(got, "load_done", 64'(got), 64'h1);
    chk(vcnt == 3, "load_valid_cycles", 64'(vcnt), 64'd3);
    chk(read_data === 32'hDEAD_BEEF, "load_read_data", read_data, 64'hDEAD_BEEF);
    req[0] = 1'b0; force_rd = 1'b0;

    // Contention with zero-wait memory.
    @(negedge clock);
    force_wait = 0;
    addr[0] = 32'h100; addr[1] = 32'h200; req[0] = 1'b1; req[1] = 1'b1;
    run_until(4);
    chk(done_ids.size() >= 4, "cont_count", 64'(done_ids.size()), 64'd4);
    for (int k = 1; k < 4 && k < done_ids.size(); k++) begin
      chk(done_ids[k] != done_ids[k-1], "cont_alternate", 64'(done_ids[k]), 64'(1 - done_ids[k-1]));
      chk(done_cyc[k] - done_cyc[k-1] == 2, "cont_spacing", 64'(done_cyc[k] - done_cyc[k-1]), 64'd2);
    end

    // Lone store requester repeats.
    @(negedge clock);
    force_wait = -1;
    we[1] = 1'b1; wd[1] = 32'h1234_5678; req[1] = 1'b1; req[0] = 1'b0;
    run_until(3);
    chk(done_ids.size() == 3, "lone_count", 64'(done_ids.size()), 64'd3);
    foreach (done_ids[k]) chk(done_ids[k] == 1, "lone_id", 64'(done_ids[k]), 64'd1);

    // Mask: held request is not re-arbitrated in its done cycle.
    @(negedge clock);
    force_wait = 0; we[1] = 1'b0; req[0] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clock);
      if (done0) got = 1'b1;
    end
    chk(got, "mask_done", 64'(got), 64'h1);
    @(negedge clock);
    chk(mem_valid === 1'b0 && grant0 === 1'b0, "mask_idle", {mem_valid, grant0}, 64'h0);
    @(negedge clock);
    chk(grant0 === 1'b1, "mask_regrant", 64'(grant0), 64'h1);
    run_until(1);

    // Reset in the second BUSY cycle abandons the access.
    @(negedge clock);
    force_wait = 5; req[0] = 1'b1;
    for (int c = 0; c < 20 && !mem_valid; c++) @(negedge clock);
    chk(mem_valid === 1'b1, "rstmid_start", 64'(mem_valid), 64'h1);
    @(negedge clock);
    reset_n = 1'b0; req[0] = 1'b0;
    @(negedge clock);
    chk({mem_valid, grant1, grant0, done0} === 4'b0, "rstmid_abort", {mem_valid, grant1, grant0, done0}, 64'h0);
    reset_n = 1'b1;
    @(negedge clock);
    chk(done0 === 1'b0 && done1 === 1'b0, "rstmid_no_done", {done1, done0}, 64'h0);
    chk(read_data === 32'h0, "rstmid_read_data", read_data, 64'h0);

    // Randomized traffic.
    force_wait = -1;
    left[0] = 40; left[1] = 40;
    gap[0] = $urandom_range(0, 3); gap[1] = $urandom_range(0, 3);
    for (int c = 0; c < 20000; c++) begin
      @(negedge clock);
      auto_step();
      if (left[0] == 0 && left[1] == 0 && !req[0] && !req[1] && !mem_valid) break;
    end
    chk(left[0] == 0 && left[1] == 0 && !req[0] && !req[1], "random_timeout",
        64'(left[0] + left[1]), 64'h0);
    repeat (3) @(negedge clock);
    chk(exp_q.size() == 0, "sb_empty", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
